// File: rtl/midi_msg_decoder_pkg.sv
// Shared constants and types for the MIDI byte-stream decoder.
package midi_msg_decoder_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] RST_CMD_DEFAULT  = 8'hFF;
  localparam logic [7:0] READ_CMD_DEFAULT = 8'hF9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2
  } state_t;

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_one_byte(input logic [3:0] kind);
    return (kind == PROG) || (kind == CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_msg_decoder.sv
// MIDI channel-voice parser with running status; emits registered fields
// plus one-cycle strobes for note events, soft reset and read-back.
module midi_msg_decoder
  import midi_msg_decoder_pkg::*;
#(
  parameter logic [7:0] READ_CMD = READ_CMD_DEFAULT,
  parameter logic [7:0] RST_CMD  = RST_CMD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_byte,
  input  logic [7:0] data,
  output logic       note_presse,
  output logic       note_release,
  output logic       note_keypress,
  output logic       note_channelpress,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       rst_cmd,
  output logic       read
);

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [3:0] channel_q, channel_d;
  logic [6:0] note_q, note_d;
  logic [6:0] velocity_q, velocity_d;
  logic       presse_q, presse_d;
  logic       release_q, release_d;
  logic       keypress_q, keypress_d;
  logic       chanpress_q, chanpress_d;
  logic       rst_cmd_q, rst_cmd_d;
  logic       read_q, read_d;

  logic       fin;
  logic [6:0] fin_d1;
  logic [6:0] fin_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      status_q    <= 8'h00;
      d1_q        <= 7'd0;
      channel_q   <= 4'd0;
      note_q      <= 7'd0;
      velocity_q  <= 7'd0;
      presse_q    <= 1'b0;
      release_q   <= 1'b0;
      keypress_q  <= 1'b0;
      chanpress_q <= 1'b0;
      rst_cmd_q   <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      channel_q   <= channel_d;
      note_q      <= note_d;
      velocity_q  <= velocity_d;
      presse_q    <= presse_d;
      release_q   <= release_d;
      keypress_q  <= keypress_d;
      chanpress_q <= chanpress_d;
      rst_cmd_q   <= rst_cmd_d;
      read_q      <= read_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    d1_d        = d1_q;
    channel_d   = channel_q;
    note_d      = note_q;
    velocity_d  = velocity_q;
    presse_d    = 1'b0;
    release_d   = 1'b0;
    keypress_d  = 1'b0;
    chanpress_d = 1'b0;
    rst_cmd_d   = 1'b0;
    read_d      = 1'b0;
    fin         = 1'b0;
    fin_d1      = d1_q;
    fin_d2      = data[6:0];

    if (valid_byte) begin
      if (data[7]) begin
        if (data >= 8'hF8) begin
          // Real-time bytes are transparent to any message in flight.
          if (data == RST_CMD) begin
            rst_cmd_d = 1'b1;
          end else if (data == READ_CMD) begin
            read_d = 1'b1;
          end
        end else if (data >= 8'hF0) begin
          status_d = 8'h00;
          state_d  = ST_IDLE;
        end else begin
          status_d = data;
          state_d  = ST_WAIT_D1;
        end
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            if (is_one_byte(status_q[7:4])) begin
              fin    = 1'b1;
              fin_d1 = data[6:0];
            end else begin
              d1_d    = data[6:0];
              state_d = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            fin     = 1'b1;
            state_d = ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    if (fin) begin
      case (status_q[7:4])
        NOTE_OFF: begin
          channel_d  = status_q[3:0];
          note_d     = fin_d1;
          velocity_d = fin_d2;
          release_d  = 1'b1;
        end
        NOTE_ON: begin
          channel_d  = status_q[3:0];
          note_d     = fin_d1;
          velocity_d = fin_d2;
          if (fin_d2 == 7'd0) begin
            release_d = 1'b1;
          end else begin
            presse_d = 1'b1;
          end
        end
        POLY_AT: begin
          channel_d  = status_q[3:0];
          note_d     = fin_d1;
          velocity_d = fin_d2;
          keypress_d = 1'b1;
        end
        CHAN_AT: begin
          channel_d   = status_q[3:0];
          velocity_d  = fin_d1;
          chanpress_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign note_presse       = presse_q;
  assign note_release      = release_q;
  assign note_keypress     = keypress_q;
  assign note_channelpress = chanpress_q;
  assign channel           = channel_q;
  assign note              = note_q;
  assign velocity          = velocity_q;
  assign rst_cmd           = rst_cmd_q;
  assign read              = read_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Directed self-checking bench for midi_msg_decoder.
module tb_midi_msg_decoder;

  logic       clk;
  logic       rst;
  logic       valid_byte;
  logic [7:0] data;
  logic       note_presse;
  logic       note_release;
  logic       note_keypress;
  logic       note_channelpress;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       rst_cmd;
  logic       read;

  int checks = 0;
  int errors = 0;

  midi_msg_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .valid_byte       (valid_byte),
    .data             (data),
    .note_presse      (note_presse),
    .note_release     (note_release),
    .note_keypress    (note_keypress),
    .note_channelpress(note_channelpress),
    .channel          (channel),
    .note             (note),
    .velocity         (velocity),
    .rst_cmd          (rst_cmd),
    .read             (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe order: presse, release, keypress, channelpress, rst_cmd, read
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ON   = 6'b100000;
  localparam logic [5:0] S_OFF  = 6'b010000;
  localparam logic [5:0] S_KP   = 6'b001000;
  localparam logic [5:0] S_CP   = 6'b000100;
  localparam logic [5:0] S_RST  = 6'b000010;
  localparam logic [5:0] S_RD   = 6'b000001;

  function automatic logic [5:0] strobes();
    return {note_presse, note_release, note_keypress, note_channelpress, rst_cmd, read};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [5:0] s, input logic [3:0] ch,
                         input logic [6:0] n, input logic [6:0] v);
    chk({tag, ".strobes"}, 32'(strobes()), 32'(s));
    chk({tag, ".channel"}, 32'(channel), 32'(ch));
    chk({tag, ".note"}, 32'(note), 32'(n));
    chk({tag, ".velocity"}, 32'(velocity), 32'(v));
  endtask

  // Called at a negedge; presents the byte for one edge and returns at the
  // next negedge, so consecutive calls drive back-to-back bytes.
  task automatic send(input logic [7:0] b);
    valid_byte = 1'b1;
    data       = b;
    @(negedge clk);
    valid_byte = 1'b0;
    data       = 8'h00;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    valid_byte = 1'b0;
    data       = 8'h00;
    repeat (3) @(negedge clk);
    chk_all("reset", S_NONE, 4'h0, 7'h00, 7'h00);
    rst = 1'b0;
    idle();

    send(8'h93); chk("on_status", 32'(strobes()), 32'(S_NONE));
    send(8'h3C); chk("on_d1", 32'(strobes()), 32'(S_NONE));
    send(8'h64); chk_all("note_on", S_ON, 4'h3, 7'h3C, 7'h64);
    idle();      chk_all("on_hold", S_NONE, 4'h3, 7'h3C, 7'h64);

    send(8'h40);
    send(8'h00); chk_all("rs_on_vel0", S_OFF, 4'h3, 7'h40, 7'h00);
    send(8'h83);
    send(8'h40);
    send(8'h10); chk_all("note_off", S_OFF, 4'h3, 7'h40, 7'h10);

    send(8'hA1);
    send(8'h30);
    send(8'h55); chk_all("poly_at", S_KP, 4'h1, 7'h30, 7'h55);
    send(8'hD2);
    send(8'h22); chk_all("chan_at", S_CP, 4'h2, 7'h30, 7'h22);
    send(8'h33); chk_all("chan_at_rs", S_CP, 4'h2, 7'h30, 7'h33);

    send(8'h90);
    send(8'h3C);
    send(8'hF8); chk("rt_mid", 32'(strobes()), 32'(S_NONE));
    send(8'h50); chk_all("on_rt", S_ON, 4'h0, 7'h3C, 7'h50);

    idle();
    send(8'hFF); chk_all("rst_cmd", S_RST, 4'h0, 7'h3C, 7'h50);
    idle();      chk("rst_cmd_len", 32'(strobes()), 32'(S_NONE));
    send(8'hF9); chk_all("read", S_RD, 4'h0, 7'h3C, 7'h50);
    send(8'hFE); chk("other_rt", 32'(strobes()), 32'(S_NONE));

    send(8'h95);
    send(8'h3C);
    send(8'hF9); chk("read_mid", 32'(strobes()), 32'(S_RD));
    send(8'h7F); chk_all("on_after_read", S_ON, 4'h5, 7'h3C, 7'h7F);

    send(8'hF0); chk("sysex_f0", 32'(strobes()), 32'(S_NONE));
    send(8'h01); chk("sysex_d1", 32'(strobes()), 32'(S_NONE));
    send(8'h02); chk("sysex_d2", 32'(strobes()), 32'(S_NONE));
    send(8'hF7); chk("sysex_f7", 32'(strobes()), 32'(S_NONE));
    send(8'h45); chk("orphan", 32'(strobes()), 32'(S_NONE));
    send(8'h46); chk_all("orphan2", S_NONE, 4'h5, 7'h3C, 7'h7F);

    send(8'hB0);
    send(8'h07);
    send(8'h7F); chk_all("cc", S_NONE, 4'h5, 7'h3C, 7'h7F);
    send(8'hC4);
    send(8'h12); chk_all("prog", S_NONE, 4'h5, 7'h3C, 7'h7F);
    send(8'hE1);
    send(8'h00);
    send(8'h40); chk_all("pitch", S_NONE, 4'h5, 7'h3C, 7'h7F);

    send(8'h95);
    send(8'h3C);
    rst = 1'b1;
    idle();      chk_all("mid_reset", S_NONE, 4'h0, 7'h00, 7'h00);
    rst = 1'b0;
    idle();
    send(8'h64); chk_all("post_reset_d", S_NONE, 4'h0, 7'h00, 7'h00);
    send(8'h64);
    idle();      chk_all("post_reset_d2", S_NONE, 4'h0, 7'h00, 7'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
